// File: rtl/sqr_pkg.sv
// Shared definitions for the iterative squarer (and its square-root sibling):
// controller state encoding, default operand width, counter sizing helper.
package sqr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } sqr_state_e;

  localparam int unsigned SQR_WIDTH_DEF = 8;

  // Smallest r with 2**r >= v; sizes the iteration counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sqr_step.sv
// One shift-add iteration of the squarer datapath (purely combinational).
module sqr_step
  import sqr_pkg::*;
#(
  parameter int unsigned WIDTH = SQR_WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0]   mplier_o
);

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
  end

endmodule

// File: rtl/sqr_iter.sv
// Iterative unsigned squarer y = a*a, one partial product per clock, using
// the start/busy/ready/done handshake shared with the square-root unit.
// Optional macro SQR_EARLY_EXIT_EN: finish as soon as the multiplier is
// exhausted (same result, data-dependent latency).
module sqr_iter
  import sqr_pkg::*;
#(
  parameter int unsigned WIDTH = SQR_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     a_bi,
  input  logic                 start_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   y_bo
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  sqr_state_e           state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   y_q, y_d;
  logic                 done_q, done_d;

  logic [2*WIDTH-1:0]   acc_nx;
  logic [2*WIDTH-1:0]   mcand_nx;
  logic [WIDTH-1:0]     mplier_nx;
  logic                 end_step;

  sqr_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_nx),
    .mcand_o  (mcand_nx),
    .mplier_o (mplier_nx)
  );

  // Decide whether this WORK edge retires the result instead of iterating.
  always_comb begin
`ifdef SQR_EARLY_EXIT_EN
    end_step = (cnt_q == CW'(WIDTH)) || (mplier_q == '0);
`else
    end_step = (cnt_q == CW'(WIDTH));
`endif
  end

  // Next-state, datapath and result update.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mcand_d  = {{WIDTH{1'b0}}, a_bi};
          mplier_d = a_bi;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = WORK;
        end
      end
      WORK: begin
        if (end_step) begin
          y_d     = acc_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          acc_d    = acc_nx;
          mcand_d  = mcand_nx;
          mplier_d = mplier_nx;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      done_q   <= done_d;
    end
  end

  // Handshake outputs derive directly from the state register.
  always_comb begin
    ready_o = (state_q == IDLE);
    busy_o  = (state_q == WORK);
    done_o  = done_q;
    y_bo    = y_q;
  end

endmodule
